// File: rtl/hs_npu_pkg.sv
// rtl/hs_npu_pkg.sv - shared types and AXI constants for the NPU memory interface
package hs_npu_pkg;

  typedef logic [31:0] uword;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B,
    ST_DRAIN
  } eng_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axib_if.sv
// rtl/axib_if.sv - AXI4 burst bundle (address, data and response channels)
interface axib_if;
  import hs_npu_pkg::*;

  logic [3:0] arid;
  uword       araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic       arvalid;
  logic       arready;

  uword       rdata;
  logic [1:0] rresp;
  logic       rlast;
  logic       rvalid;
  logic       rready;

  logic [3:0] awid;
  uword       awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic       awvalid;
  logic       awready;

  uword       wdata;
  logic [3:0] wstrb;
  logic       wlast;
  logic       wvalid;
  logic       wready;

  logic [1:0] bresp;
  logic       bvalid;
  logic       bready;

  modport m (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport s (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/hs_npu_axi_burst_engine.sv
// rtl/hs_npu_axi_burst_engine.sv - single-burst AXI4 read/write master
// Response checking (err_o) is built only with HS_NPU_MEMIF_RESP_CHECK_EN defined.
module hs_npu_axi_burst_engine
  import hs_npu_pkg::*;
#(
  parameter int BEATS     = 4,
  parameter int BEAT_SIZE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_write_i,
  input  uword             req_addr_i,
  input  uword [BEATS-1:0] wr_data_i,
  input  logic             abort_i,
  output uword [BEATS-1:0] rd_data_o,
  output logic             done_o,
  output logic             err_o,
  axib_if.m                axi
);

  localparam int            BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  eng_state_e       state_q, state_d;
  logic [BW-1:0]    beat_q;
  logic             full_q;
  logic             abort_q;
  uword             addr_q;
  uword [BEATS-1:0] wdata_q;
  uword [BEATS-1:0] rd_data_q;
  logic             done_q;
  logic             accept;

  assign accept = req_valid_i && (state_q == ST_IDLE);

  assign axi.arid    = '0;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = 8'(BEATS - 1);
  assign axi.arsize  = 3'(BEAT_SIZE);
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.awid    = '0;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = 8'(BEATS - 1);
  assign axi.awsize  = 3'(BEAT_SIZE);
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.wdata   = wdata_q[beat_q];
  assign axi.wstrb   = '1;
  assign axi.wlast   = (state_q == ST_W) && (beat_q == LAST_BEAT);

  assign rd_data_o = rd_data_q;
  assign done_o    = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = req_write_i ? ST_AW : ST_AR;
      end
      ST_AR: begin
        // An abort seen while waiting still has to complete the AR handshake.
        axi.arvalid = 1'b1;
        if (axi.arready) state_d = (abort_i || abort_q) ? ST_DRAIN : ST_R;
      end
      ST_R: begin
        axi.rready = 1'b1;
        if (abort_i)                       state_d = (axi.rvalid && axi.rlast) ? ST_IDLE : ST_DRAIN;
        else if (axi.rvalid && axi.rlast)  state_d = ST_IDLE;
      end
      ST_AW: begin
        axi.awvalid = 1'b1;
        if (axi.awready) state_d = ST_W;
      end
      ST_W: begin
        axi.wvalid = 1'b1;
        if (axi.wready && (beat_q == LAST_BEAT)) state_d = ST_B;
      end
      ST_B: begin
        axi.bready = 1'b1;
        if (axi.bvalid) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        axi.rready = 1'b1;
        if (axi.rvalid && axi.rlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q    <= '0;
      full_q    <= 1'b0;
      abort_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        addr_q  <= req_addr_i;
        wdata_q <= wr_data_i;
        beat_q  <= '0;
        full_q  <= 1'b0;
        abort_q <= 1'b0;
      end
      case (state_q)
        ST_AR: if (abort_i) abort_q <= 1'b1;
        ST_R: begin
          // full_q marks that the last slot is written; later beats are dropped.
          if (axi.rvalid && !abort_i) begin
            if (!full_q) rd_data_q[beat_q] <= axi.rdata;
            if (beat_q == LAST_BEAT) full_q <= 1'b1;
            else                     beat_q <= beat_q + BW'(1);
            if (axi.rlast) done_q <= 1'b1;
          end
        end
        ST_W: if (axi.wready && (beat_q != LAST_BEAT)) beat_q <= beat_q + BW'(1);
        ST_B: if (axi.bvalid) done_q <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef HS_NPU_MEMIF_RESP_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else begin
      if ((state_q == ST_R) && axi.rvalid && !abort_i) begin
        if (axi.rresp != AXI_RESP_OKAY)                              err_q <= 1'b1;
        if (axi.rlast && (full_q || (beat_q != LAST_BEAT)))          err_q <= 1'b1;
        if (!axi.rlast && !full_q && (beat_q == LAST_BEAT))          err_q <= 1'b1;
      end
      if ((state_q == ST_B) && axi.bvalid && (axi.bresp != AXI_RESP_OKAY)) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
